// File: rtl/pong_match_ctrl_if.sv
// Match controller bus: frame/button/miss inputs toward the sequencer and
// ball-gating, score and status outputs back to the datapath and display.
interface pong_match_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               start_btn;
  logic               miss_left;
  logic               miss_right;
  logic               ball_run;
  logic               ball_reset;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic               game_over;
  logic               winner;
  logic [2:0]         state;

  modport master (
    output frame_tick, start_btn, miss_left, miss_right,
    input  ball_run, ball_reset, serve_dir, score_left, score_right,
    input  game_over, winner, state
  );

  modport slave (
    input  frame_tick, start_btn, miss_left, miss_right,
    output ball_run, ball_reset, serve_dir, score_left, score_right,
    output game_over, winner, state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/point/over FSM, score keeping and winner.
// Define PONG_WIN_BY_TWO_EN for win-by-two scoring with deuce fold.
module pong_match_ctrl #(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int CNT_W        = 7
) (
  input  logic             clk,
  input  logic             reset,
  pong_match_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] WIN_V      = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES - 1);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [SCORE_W-1:0] score_left_reg;
  logic [SCORE_W-1:0] score_right_reg;
  logic               ball_run_reg;
  logic               ball_reset_reg;
  logic               serve_dir_reg;
  logic               game_over_reg;
  logic               winner_reg;

  logic [SCORE_W-1:0] left_inc;
  logic [SCORE_W-1:0] right_inc;
  logic [SCORE_W-1:0] left_next;
  logic [SCORE_W-1:0] right_next;
  logic               win_left;
  logic               win_right;

  // Saturating increments keep scores from wrapping.
  assign left_inc  = (score_left_reg == SCORE_MAX) ? score_left_reg
                                                   : score_left_reg + SCORE_W'(1);
  assign right_inc = (score_right_reg == SCORE_MAX) ? score_right_reg
                                                    : score_right_reg + SCORE_W'(1);

  always_comb begin
    left_next  = score_left_reg;
    right_next = score_right_reg;
    if (bus.miss_left && !bus.miss_right) begin
      right_next = right_inc;
    end else if (bus.miss_right && !bus.miss_left) begin
      left_next = left_inc;
    end
`ifdef PONG_WIN_BY_TWO_EN
    // Deuce fold: tied at or above the target drops both back by one.
    if ((left_next == right_next) && (left_next >= WIN_V)) begin
      left_next  = WIN_V - SCORE_W'(1);
      right_next = WIN_V - SCORE_W'(1);
    end
`endif
  end

`ifdef PONG_WIN_BY_TWO_EN
  logic [SCORE_W:0] left_x;
  logic [SCORE_W:0] right_x;
  assign left_x    = {1'b0, score_left_reg};
  assign right_x   = {1'b0, score_right_reg};
  assign win_left  = (score_left_reg >= WIN_V) && (left_x >= right_x + (SCORE_W+1)'(2));
  assign win_right = (score_right_reg >= WIN_V) && (right_x >= left_x + (SCORE_W+1)'(2));
`else
  assign win_left  = (score_left_reg >= WIN_V);
  assign win_right = (score_right_reg >= WIN_V);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      score_left_reg  <= '0;
      score_right_reg <= '0;
      ball_run_reg    <= 1'b0;
      ball_reset_reg  <= 1'b0;
      serve_dir_reg   <= 1'b0;
      game_over_reg   <= 1'b0;
      winner_reg      <= 1'b0;
    end else begin
      ball_reset_reg <= 1'b0;
      case (state_reg)
        IDLE, OVER: begin
          if (bus.start_btn) begin
            state_reg       <= SERVE;
            cnt_reg         <= SERVE_LOAD;
            score_left_reg  <= '0;
            score_right_reg <= '0;
            serve_dir_reg   <= 1'b1;
            ball_reset_reg  <= 1'b1;
            game_over_reg   <= 1'b0;
          end
        end
        SERVE: begin
          if (bus.frame_tick) begin
            if (cnt_reg == '0) begin
              state_reg    <= PLAY;
              ball_run_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
        end
        PLAY: begin
          if (bus.miss_left || bus.miss_right) begin
            state_reg       <= POINT;
            ball_run_reg    <= 1'b0;
            cnt_reg         <= POINT_LOAD;
            score_left_reg  <= left_next;
            score_right_reg <= right_next;
            // Next serve heads toward whoever lost the point; a let keeps it.
            if (bus.miss_left && !bus.miss_right) begin
              serve_dir_reg <= 1'b0;
            end else if (bus.miss_right && !bus.miss_left) begin
              serve_dir_reg <= 1'b1;
            end
          end
        end
        POINT: begin
          if (bus.frame_tick) begin
            if (cnt_reg == '0) begin
              if (win_left || win_right) begin
                state_reg     <= OVER;
                game_over_reg <= 1'b1;
                winner_reg    <= win_right;
              end else begin
                state_reg      <= SERVE;
                cnt_reg        <= SERVE_LOAD;
                ball_reset_reg <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ball_run    = ball_run_reg;
  assign bus.ball_reset  = ball_reset_reg;
  assign bus.serve_dir   = serve_dir_reg;
  assign bus.score_left  = score_left_reg;
  assign bus.score_right = score_right_reg;
  assign bus.game_over   = game_over_reg;
  assign bus.winner      = winner_reg;
  assign bus.state       = state_reg;

endmodule
